// File: rtl/rv32i_hazard_ctrl.sv
// Hazard controller for the RV32I pipeline: load-use stalls, redirect flushes,
// data-memory freezes and saturating stall/flush performance counters.
module rv32i_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                 Clk,
    input  logic                 Reset,
    input  logic [31:0]          IF_Instruction,
    input  logic                 ID_Mem_rd_en,
    input  logic [4:0]           ID_Rd_addr,
    input  logic                 EX_Branch_taken,
    input  logic                 Dmem_req,
    input  logic                 Dmem_ready,
    input  logic                 Cnt_clear,
    output logic                 PC_Stall,
    output logic                 IF_Stall,
    output logic                 ID_Stall,
    output logic                 IF_Flush,
    output logic                 ID_Flush,
    output logic                 Pipe_freeze,
    output logic [CNT_WIDTH-1:0] Stall_cycles,
    output logic [CNT_WIDTH-1:0] Flush_count
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        FLUSH    = 2'd1,
        MEM_WAIT = 2'd2
    } state_e;

    localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);
    localparam bit         MULTI_FLUSH  = (FLUSH_CYCLES > 1);

    state_e               state_q, state_d;
    logic [2:0]           fcnt_q, fcnt_d;
    logic                 pending_q, pending_d;
    logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_WIDTH-1:0] flush_cnt_q, flush_cnt_d;

    logic [6:0] opcode;
    logic [4:0] rs1, rs2;
    logic       uses_rs1, uses_rs2, load_use, mem_busy;
    logic       unused_instr_bits;

    assign opcode   = IF_Instruction[6:0];
    assign rs1      = IF_Instruction[19:15];
    assign rs2      = IF_Instruction[24:20];
    assign unused_instr_bits = ^{IF_Instruction[31:25], IF_Instruction[14:7]};

    // LUI, AUIPC and JAL carry no rs1; only R-type, stores and branches read rs2.
    assign uses_rs1 = !(opcode inside {7'b0110111, 7'b0010111, 7'b1101111});
    assign uses_rs2 = opcode inside {7'b0110011, 7'b0100011, 7'b1100011};
    assign load_use = ID_Mem_rd_en && (ID_Rd_addr != 5'd0) &&
                      ((uses_rs1 && (rs1 == ID_Rd_addr)) || (uses_rs2 && (rs2 == ID_Rd_addr)));
    assign mem_busy = Dmem_req && !Dmem_ready;

    logic do_redirect, do_stall, do_freeze, do_flush;

    always_comb begin
        // NOTE: every always_comb target gets a default first so no path can infer a latch.
        state_d     = state_q;
        fcnt_d      = fcnt_q;
        pending_d   = pending_q;
        do_redirect = 1'b0;
        do_stall    = 1'b0;
        do_freeze   = 1'b0;
        do_flush    = 1'b0;

        unique case (state_q)
            RUN: begin
                if (mem_busy) begin
                    do_freeze = 1'b1;
                    pending_d = EX_Branch_taken;
                    state_d   = MEM_WAIT;
                end else if (EX_Branch_taken) begin
                    do_redirect = 1'b1;
                end else if (load_use) begin
                    do_stall = 1'b1;
                end
            end
            FLUSH: begin
                if (mem_busy) begin
                    do_freeze = 1'b1;
                end else if (EX_Branch_taken) begin
                    do_redirect = 1'b1;
                end else begin
                    do_flush = 1'b1;
                    fcnt_d   = fcnt_q - 3'd1;
                    if (fcnt_q == 3'd1) state_d = RUN;
                end
            end
            MEM_WAIT: begin
                if (mem_busy) begin
                    do_freeze = 1'b1;
                    pending_d = pending_q | EX_Branch_taken;
                end else if (pending_q || EX_Branch_taken) begin
                    do_redirect = 1'b1;
                    pending_d   = 1'b0;
                end else begin
                    state_d   = RUN;
                    pending_d = 1'b0;
                    do_stall  = load_use;
                end
            end
            default: begin
                state_d   = RUN;
                fcnt_d    = 3'd0;
                pending_d = 1'b0;
            end
        endcase

        // The detecting cycle is the first of FLUSH_CYCLES flush cycles.
        if (do_redirect) begin
            do_flush = 1'b1;
            if (MULTI_FLUSH) begin
                fcnt_d  = FLUSH_RELOAD;
                state_d = FLUSH;
            end else begin
                state_d = RUN;
            end
        end

        stall_cnt_d = stall_cnt_q;
        if (Cnt_clear) begin
            stall_cnt_d = '0;
        end else if ((do_stall || do_freeze) && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + CNT_WIDTH'(1);
        end

        flush_cnt_d = flush_cnt_q;
        if (Cnt_clear) begin
            flush_cnt_d = '0;
        end else if (do_redirect && (flush_cnt_q != '1)) begin
            flush_cnt_d = flush_cnt_q + CNT_WIDTH'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q     <= RUN;
            fcnt_q      <= 3'd0;
            pending_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            fcnt_q      <= fcnt_d;
            pending_q   <= pending_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // Reset forces every control output low without waiting for a clock edge.
    assign PC_Stall     = do_stall  && !Reset;
    assign IF_Stall     = do_stall  && !Reset;
    assign ID_Stall     = do_stall  && !Reset;
    assign IF_Flush     = do_flush  && !Reset;
    assign ID_Flush     = do_flush  && !Reset;
    assign Pipe_freeze  = do_freeze && !Reset;
    assign Stall_cycles = stall_cnt_q;
    assign Flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_rv32i_hazard_ctrl.sv
// Self-checking bench for rv32i_hazard_ctrl: directed vector table, corner-case
// sequences, and randomized traffic against a rule-level reference model.
module tb_rv32i_hazard_ctrl;

    localparam int FC = 2;
    localparam int CW = 4;
    localparam int CNT_MAX = (1 << CW) - 1;

    localparam logic [31:0] ADD_X6_X5_X1  = 32'h00128333;
    localparam logic [31:0] LUI_X5        = 32'h000052B7;
    localparam logic [31:0] NOP           = 32'h00000013;
    localparam logic [31:0] ADDI_X6_X5_1  = 32'h00128313;

    logic          Clk = 1'b0;
    logic          Reset = 1'b1;
    logic [31:0]   IF_Instruction = NOP;
    logic          ID_Mem_rd_en = 1'b0;
    logic [4:0]    ID_Rd_addr = 5'd0;
    logic          EX_Branch_taken = 1'b0;
    logic          Dmem_req = 1'b0;
    logic          Dmem_ready = 1'b0;
    logic          Cnt_clear = 1'b0;
    logic          PC_Stall, IF_Stall, ID_Stall, IF_Flush, ID_Flush, Pipe_freeze;
    logic [CW-1:0] Stall_cycles, Flush_count;
    logic [5:0]    ctl;

    rv32i_hazard_ctrl #(.FLUSH_CYCLES(FC), .CNT_WIDTH(CW)) dut (
        .Clk(Clk), .Reset(Reset), .IF_Instruction(IF_Instruction),
        .ID_Mem_rd_en(ID_Mem_rd_en), .ID_Rd_addr(ID_Rd_addr),
        .EX_Branch_taken(EX_Branch_taken), .Dmem_req(Dmem_req),
        .Dmem_ready(Dmem_ready), .Cnt_clear(Cnt_clear),
        .PC_Stall(PC_Stall), .IF_Stall(IF_Stall), .ID_Stall(ID_Stall),
        .IF_Flush(IF_Flush), .ID_Flush(ID_Flush), .Pipe_freeze(Pipe_freeze),
        .Stall_cycles(Stall_cycles), .Flush_count(Flush_count)
    );

    always #5 Clk = ~Clk;

    assign ctl = {PC_Stall, IF_Stall, ID_Stall, IF_Flush, ID_Flush, Pipe_freeze};

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] instr, input logic rd_en, input logic [4:0] rd,
                         input logic br, input logic req, input logic rdy, input logic clr);
        IF_Instruction  = instr;
        ID_Mem_rd_en    = rd_en;
        ID_Rd_addr      = rd;
        EX_Branch_taken = br;
        Dmem_req        = req;
        Dmem_ready      = rdy;
        Cnt_clear       = clr;
    endtask

    task automatic idle();
        drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // ---------------- reference model ----------------
    int m_flush_left, nx_flush_left;
    bit m_wait, nx_wait, m_pend, nx_pend;
    int m_stall, nx_stall, m_flushes, nx_flushes;

    function automatic bit ref_load_use();
        logic [6:0] op;
        bit r1, r2;
        op = IF_Instruction[6:0];
        r1 = !(op == 7'b0110111 || op == 7'b0010111 || op == 7'b1101111);
        r2 = (op == 7'b0110011 || op == 7'b0100011 || op == 7'b1100011);
        return ID_Mem_rd_en && ID_Rd_addr != 0 &&
               ((r1 && IF_Instruction[19:15] == ID_Rd_addr) ||
                (r2 && IF_Instruction[24:20] == ID_Rd_addr));
    endfunction

    task automatic model_eval(output logic [5:0] e);
        bit busy, lu, redirect, stall, freeze, flush;
        busy = Dmem_req && !Dmem_ready;
        lu = ref_load_use();
        redirect = 0; stall = 0; freeze = 0; flush = 0;
        nx_flush_left = m_flush_left; nx_wait = m_wait; nx_pend = m_pend;
        if (m_wait) begin
            if (busy) begin
                freeze = 1; nx_pend = m_pend | EX_Branch_taken;
            end else begin
                nx_wait = 0; nx_pend = 0;
                if (m_pend || EX_Branch_taken) redirect = 1;
                else stall = lu;
            end
        end else if (m_flush_left > 0) begin
            if (busy) freeze = 1;
            else if (EX_Branch_taken) redirect = 1;
            else begin
                flush = 1; nx_flush_left = m_flush_left - 1;
            end
        end else begin
            if (busy) begin
                freeze = 1; nx_wait = 1; nx_pend = EX_Branch_taken;
            end else if (EX_Branch_taken) redirect = 1;
            else stall = lu;
        end
        if (redirect) begin
            flush = 1; nx_flush_left = FC - 1;
        end
        nx_stall   = Cnt_clear ? 0 : ((stall || freeze) ? ((m_stall + 1 > CNT_MAX) ? CNT_MAX : m_stall + 1) : m_stall);
        nx_flushes = Cnt_clear ? 0 : (redirect ? ((m_flushes + 1 > CNT_MAX) ? CNT_MAX : m_flushes + 1) : m_flushes);
        e = {stall, stall, stall, flush, flush, freeze};
    endtask

    task automatic model_commit();
        m_flush_left = nx_flush_left; m_wait = nx_wait; m_pend = nx_pend;
        m_stall = nx_stall; m_flushes = nx_flushes;
    endtask

    task automatic model_reset();
        m_flush_left = 0; m_wait = 0; m_pend = 0; m_stall = 0; m_flushes = 0;
    endtask

    task automatic do_reset();
        Reset = 1'b1;
        idle();
        @(posedge Clk);
        #1 Reset = 1'b0;
        model_reset();
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [31:0] instr;
        logic        rd_en;
        logic [4:0]  rd;
        logic        br, req, rdy, clr;
        logic [5:0]  exp_ctl;
        int          exp_stall;
        int          exp_flush;
    } vec_t;

    vec_t vecs[$];

    task automatic add_vec(input logic [31:0] instr, input logic rd_en, input logic [4:0] rd,
                           input logic br, input logic req, input logic rdy, input logic clr,
                           input logic [5:0] exp_ctl, input int st, input int fl);
        vec_t v;
        v.instr = instr; v.rd_en = rd_en; v.rd = rd; v.br = br; v.req = req; v.rdy = rdy;
        v.clr = clr; v.exp_ctl = exp_ctl; v.exp_stall = st; v.exp_flush = fl;
        vecs.push_back(v);
    endtask

    logic [5:0] e_ctl;
    logic [31:0] rnd_instr;
    logic [6:0]  ops [9] = '{7'b0110011, 7'b0100011, 7'b1100011, 7'b0010011, 7'b0000011,
                             7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};

    initial begin
        // exp counters are the values visible during that cycle, before its update.
        add_vec(ADD_X6_X5_X1, 1, 5, 0, 0, 0, 0, 6'b111000, 0, 0); // load-use stall
        add_vec(ADD_X6_X5_X1, 0, 5, 0, 0, 0, 0, 6'b000000, 1, 0); // bubble released
        add_vec(ADD_X6_X5_X1, 1, 0, 0, 0, 0, 0, 6'b000000, 1, 0); // rd = x0
        add_vec(LUI_X5,       1, 5, 0, 0, 0, 0, 6'b000000, 1, 0); // lui has no rs1
        add_vec(ADD_X6_X5_X1, 1, 5, 1, 0, 0, 0, 6'b000110, 1, 0); // redirect beats load-use
        add_vec(NOP,          0, 0, 0, 0, 0, 0, 6'b000110, 1, 1); // second flush cycle
        add_vec(NOP,          0, 0, 0, 0, 0, 0, 6'b000000, 1, 1);
        add_vec(NOP,          0, 0, 1, 1, 0, 0, 6'b000001, 1, 1); // freeze + pending redirect
        add_vec(NOP,          0, 0, 0, 1, 0, 0, 6'b000001, 2, 1);
        add_vec(NOP,          0, 0, 0, 1, 0, 0, 6'b000001, 3, 1);
        add_vec(NOP,          0, 0, 0, 1, 1, 0, 6'b000110, 4, 1); // ready: pending flush
        add_vec(NOP,          0, 0, 0, 0, 0, 0, 6'b000110, 4, 2);
        add_vec(NOP,          0, 0, 0, 0, 0, 0, 6'b000000, 4, 2);
        add_vec(NOP,          0, 0, 0, 0, 0, 1, 6'b000000, 4, 2); // clear
        add_vec(ADD_X6_X5_X1, 1, 1, 0, 0, 0, 0, 6'b111000, 0, 0); // rs2 hazard
        add_vec(ADDI_X6_X5_1, 1, 1, 0, 0, 0, 0, 6'b000000, 1, 0); // I-type rs2 field ignored
        add_vec(NOP,          0, 0, 0, 0, 0, 0, 6'b000000, 1, 0);

        // Outputs low during reset even with a busy memory request.
        drive(ADD_X6_X5_X1, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0);
        #12;
        check("reset_ctl", 32'(ctl), 32'd0);
        check("reset_stall_cnt", 32'(Stall_cycles), 32'd0);
        check("reset_flush_cnt", 32'(Flush_count), 32'd0);
        do_reset();

        foreach (vecs[i]) begin
            drive(vecs[i].instr, vecs[i].rd_en, vecs[i].rd, vecs[i].br,
                  vecs[i].req, vecs[i].rdy, vecs[i].clr);
            @(negedge Clk);
            check($sformatf("vec%0d_ctl", i), 32'(ctl), 32'(vecs[i].exp_ctl));
            check($sformatf("vec%0d_stall_cnt", i), 32'(Stall_cycles), 32'(vecs[i].exp_stall));
            check($sformatf("vec%0d_flush_cnt", i), 32'(Flush_count), 32'(vecs[i].exp_flush));
            @(posedge Clk);
            #1;
        end

        // Saturation: 20 consecutive load-use cycles on a 4-bit counter.
        drive(NOP, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1);
        @(posedge Clk); #1;
        drive(ADD_X6_X5_X1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        repeat (20) begin
            @(posedge Clk); #1;
        end
        idle();
        @(negedge Clk);
        check("sat_stall_cnt", 32'(Stall_cycles), 32'(CNT_MAX));
        @(posedge Clk); #1;
        drive(ADD_X6_X5_X1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        @(negedge Clk);
        check("clear_with_stall_ctl", 32'(ctl), 32'b111000);
        @(posedge Clk); #1;
        idle();
        @(negedge Clk);
        check("clear_priority_cnt", 32'(Stall_cycles), 32'd0);
        @(posedge Clk); #1;

        // Reset asserted during the second flush cycle.
        drive(NOP, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        check("rst_seq_flush1", 32'(ctl), 32'b000110);
        @(posedge Clk); #1;
        idle();
        @(negedge Clk);
        check("rst_seq_flush2", 32'(ctl), 32'b000110);
        #1 Reset = 1'b1;
        #1;
        check("rst_async_ctl", 32'(ctl), 32'd0);
        check("rst_async_flush_cnt", 32'(Flush_count), 32'd0);
        @(posedge Clk); #1;
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_after_idle", 32'(ctl), 32'd0);
        @(posedge Clk); #1;
        drive(ADD_X6_X5_X1, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge Clk);
        check("rst_after_run_stall", 32'(ctl), 32'b111000);
        @(posedge Clk); #1;

        // Randomized traffic against the reference model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            rnd_instr = $urandom();
            rnd_instr[6:0]   = ops[$urandom_range(0, 8)];
            rnd_instr[19:15] = 5'($urandom_range(0, 3));
            rnd_instr[24:20] = 5'($urandom_range(0, 3));
            drive(rnd_instr, 1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)),
                  ($urandom_range(0, 6) == 0),
                  (Dmem_req && !Dmem_ready) ? 1'b1 : ($urandom_range(0, 4) == 0),
                  ($urandom_range(0, 2) == 0),
                  ($urandom_range(0, 40) == 0));
            @(negedge Clk);
            model_eval(e_ctl);
            check("rand_ctl", 32'(ctl), 32'(e_ctl));
            check("rand_stall_cnt", 32'(Stall_cycles), 32'(m_stall));
            check("rand_flush_cnt", 32'(Flush_count), 32'(m_flushes));
            @(posedge Clk); #1;
            model_commit();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
